wide_add_seq: RTL

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

---
 rtl/wide_add_seq_pkg.sv | 18 +
 rtl/wide_add_seq_clsa.sv | 27 ++
 rtl/wide_add_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/wide_add_seq_pkg.sv
// Shared types and constants for the sliced sequential wide adder.
package wide_add_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SLICE_W        = 16;
  localparam int DEF_NUM_SLICES = 4;

  // A one-slice build still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wide_add_seq_clsa.sv
// 16-bit carry-select adder: four 4-bit groups, each precomputing both carry cases.
module CLSA_16_bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);

  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < 4; g++) begin : g_grp
    logic [4:0] w_s0;
    logic [4:0] w_s1;

    assign w_s0 = {1'b0, i_a[g*4 +: 4]} + {1'b0, i_b[g*4 +: 4]};
    assign w_s1 = {1'b0, i_a[g*4 +: 4]} + {1'b0, i_b[g*4 +: 4]} + 5'd1;

    assign o_sum[g*4 +: 4] = w_c[g] ? w_s1[3:0] : w_s0[3:0];
    assign w_c[g+1]        = w_c[g] ? w_s1[4]   : w_s0[4];
  end

  assign o_cout = w_c[4];

endmodule

// File: rtl/wide_add_seq.sv
// Wide add/subtract processed one 16-bit slice per cycle through a shared CLSA.
//   state   | meaning
//   IDLE    | ready for a new operation
//   RUN     | adding slice r_k, carry in r_c
//   DONE    | result presented until Res_ready
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int NUM_SLICES = DEF_NUM_SLICES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          In_valid,
  output logic                          In_ready,
  input  logic [SLICE_W*NUM_SLICES-1:0] A,
  input  logic [SLICE_W*NUM_SLICES-1:0] B,
  input  logic                          Cin,
  input  logic                          Sub,
  output logic                          Res_valid,
  input  logic                          Res_ready,
  output logic [SLICE_W*NUM_SLICES-1:0] S,
  output logic                          Co,
  output logic                          Ovf,
  output logic                          Busy
);

  localparam int W   = SLICE_W * NUM_SLICES;
  localparam int K_W = cnt_width(NUM_SLICES);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_s;
  logic             r_c;
  logic [K_W-1:0]   r_k;

  logic             w_accept;
  logic             w_last;
  logic [31:0]      w_base;
  logic [15:0]      w_sum;
  logic             w_cout;
  logic             w_done;
  logic             w_ovf;

  assign w_accept = In_valid && (r_state == ST_IDLE);
  assign w_last   = (r_k == K_W'(NUM_SLICES - 1));
  assign w_base   = 32'(r_k) * 32'(SLICE_W);

  CLSA_16_bit u_clsa (
    .i_a    (r_a[w_base +: SLICE_W]),
    .i_b    (r_b[w_base +: SLICE_W]),
    .i_cin  (r_c),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: if (Res_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // B is stored pre-inverted so subtraction is just A + ~B + 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_s <= '0;
      r_c <= 1'b0;
      r_k <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a <= A;
            r_b <= Sub ? ~B : B;
            r_c <= Sub ? 1'b1 : Cin;
            r_k <= '0;
          end
        end
        ST_RUN: begin
          r_s[w_base +: SLICE_W] <= w_sum;
          r_c                    <= w_cout;
          r_k                    <= r_k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_done = (r_state == ST_DONE);
  assign w_ovf  = (r_a[W-1] == r_b[W-1]) && (r_s[W-1] != r_a[W-1]);

  assign In_ready  = (r_state == ST_IDLE);
  assign Res_valid = w_done;
  assign Busy      = (r_state != ST_IDLE);
  assign S         = r_s;
  assign Co        = w_done && r_c;
  assign Ovf       = w_done && w_ovf;

endmodule
